// File: rtl/data_mem_unit.sv
// Byte-addressed little-endian data memory with a fixed-latency request/response handshake.
// Loads are size-selectable and sign- or zero-extended; misaligned or out-of-range accesses fault.
module data_mem_unit #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] adr,
    input  logic [63:0] datain,
    output logic        rsp_valid,
    output logic [63:0] dataout,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] adr;
        logic [63:0] data;
    } req_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    req_t          req_q, req_c;
    logic          accept_c, fire_c, fault_c;
    logic [7:0]    bmask_c;
    logic [2:0]    amask_c;
    logic [63:0]   nbytes_c;
    logic [AW-1:0] base_c;
    logic [7:0]    rbyte_c [8];
    logic [63:0]   rdata_c, ext_c;
    logic [7:0]    mem [DEPTH];

    // With zero wait states the access completes on the accepting edge, so use live inputs in IDLE.
    assign req_c = (state == S_IDLE) ? {req_we, req_size, req_unsigned, adr, datain} : req_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept_c = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = S_RESP;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Access size decode: byte lanes, alignment mask and byte count.
    always_comb begin
        bmask_c  = 8'h00;
        amask_c  = 3'b000;
        nbytes_c = 64'd0;
        case (req_c.size)
            2'd0: begin bmask_c = 8'h01; amask_c = 3'b000; nbytes_c = 64'd1; end
            2'd1: begin bmask_c = 8'h03; amask_c = 3'b001; nbytes_c = 64'd2; end
            2'd2: begin bmask_c = 8'h0F; amask_c = 3'b011; nbytes_c = 64'd4; end
            default: begin bmask_c = 8'hFF; amask_c = 3'b111; nbytes_c = 64'd8; end
        endcase
    end

    assign fault_c = (|(req_c.adr[2:0] & amask_c)) || (req_c.adr > (64'(DEPTH) - nbytes_c));
    assign base_c  = req_c.adr[AW-1:0];
    assign fire_c  = (state_next == S_RESP) && !reset;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            rbyte_c[k] = bmask_c[k] ? mem[base_c + AW'(k)] : 8'h00;
        end
        rdata_c = {rbyte_c[7], rbyte_c[6], rbyte_c[5], rbyte_c[4],
                   rbyte_c[3], rbyte_c[2], rbyte_c[1], rbyte_c[0]};
        case (req_c.size)
            2'd0:    ext_c = {{56{rdata_c[7]  & ~req_c.uns}}, rdata_c[7:0]};
            2'd1:    ext_c = {{48{rdata_c[15] & ~req_c.uns}}, rdata_c[15:0]};
            2'd2:    ext_c = {{32{rdata_c[31] & ~req_c.uns}}, rdata_c[31:0]};
            default: ext_c = rdata_c;
        endcase
    end

    // Array is never reset; stores commit on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (fire_c && req_c.we && !fault_c) begin
            for (int k = 0; k < 8; k++) begin
                if (bmask_c[k]) mem[base_c + AW'(k)] <= req_c.data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_q     <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            dataout   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            req_ready <= (state_next == S_IDLE);
            rsp_valid <= (state_next == S_RESP);
            if (accept_c) req_q <= req_c;
            if (fire_c) begin
                rsp_err <= fault_c;
                dataout <= (fault_c || req_c.we) ? 64'd0 : ext_c;
            end
        end
    end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DEPTH, default 256: memory size in bytes; power of two, at least 8.
REQ-002 Parameter WAIT_CYCLES, default 1: extra access wait states, range 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-009 req_unsigned  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-010 adr  input  64  byte address.
REQ-011 datain  input  64  store data; the low 2^req_size bytes are used.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 dataout  output  64  load result; driven at all times, never high-impedance.
REQ-014 rsp_err  output  1  the completed access faulted; valid only with rsp_valid.

Function
REQ-015 The SHALL use a byte-organised little-endian array of DEPTH bytes; byte k of an access SHALL be stored at address adr+k.
REQ-016 The FSM SHALL have three states:
- IDLE: req_ready=1.
- WAIT: req_ready=0.
- RESP: req_ready=0, rsp_valid=1.
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1 and the FSM is in IDLE.
- All request inputs SHALL be registered at acceptance.
- Later changes to request inputs SHALL be ignored until the next acceptance.
REQ-018 On acceptance, with WAIT_CYCLES>0 the FSM SHALL go IDLE->WAIT and load the wait counter with WAIT_CYCLES-1. With WAIT_CYCLES=0 it SHALL go IDLE->RESP.
REQ-019 In WAIT, the counter SHALL decrement each cycle. The FSM SHALL move WAIT->RESP on the edge where the counter equals 0.
REQ-020 RESP SHALL last exactly one cycle, then the FSM SHALL return to IDLE.
- Back-to-back requests are therefore spaced WAIT_CYCLES+2 cycles apart.
- A request held on req_valid during RESP SHALL NOT be accepted until IDLE.
REQ-021 rsp_valid SHALL be high in the cycle beginning WAIT_CYCLES+1 edges after the accepting edge.
REQ-022 The array write (store) and the dataout/rsp_err update SHALL occur on the edge that enters RESP.
REQ-023 A store SHALL write exactly 2^req_size bytes from datain[8*2^req_size-1:0]. All other bytes SHALL be unchanged.
REQ-024 A load SHALL read 2^req_size bytes and then extend them to 64 bits as set by req_unsigned. For doubles the extension SHALL have no effect.
REQ-025 A fault SHALL be raised in either of these cases:
- misaligned: adr mod 2^req_size != 0;
- out of range: adr > DEPTH-2^req_size.
For a fault, the unit SHALL set rsp_err=1, SHALL NOT write the array, and SHALL set dataout=0.
REQ-026 On a non-faulting access rsp_err SHALL be 0. After a store, dataout SHALL be 0.
REQ-027 dataout and rsp_err SHALL hold their values until the next RESP entry.
REQ-028 A load to the address of the immediately preceding store SHALL return the newly written data.

Reset
REQ-029 Asserting reset SHALL immediately force:
- FSM to IDLE;
- wait counter, dataout and rsp_err to 0;
- rsp_valid to 0;
- req_ready to 1 after deassertion.
REQ-030 Reset mid-request (in WAIT or before the RESP edge) SHALL discard the request with no array write and no response.
REQ-031 Array contents SHALL NOT be reset.

Verification
REQ-032 WAIT_CYCLES=1:
- store double 0x1122334455667788 at adr 8 -> rsp_valid two edges after acceptance, rsp_err=0.
- then load double at adr 8 -> 0x1122334455667788.
REQ-033 Store byte 0x80 at adr 3, then:
- signed byte load -> 0xFFFFFFFFFFFFFF80;
- unsigned byte load -> 0x0000000000000080;
- word load at adr 0 shows byte 3 = 0x80, other bytes unchanged.
REQ-034 Misaligned and out-of-range faults:
- half store at adr 1 -> rsp_err=1, memory unchanged;
- double load at adr DEPTH-4 -> rsp_err=1, dataout=0.
REQ-035 Assert reset in WAIT during a store of 0xAA at adr 5 -> no rsp_valid, adr 5 retains its old value, req_ready=1 after reset.
REQ-036 WAIT_CYCLES=0 with req_valid held high -> accepts every 2 cycles and rsp_valid every 2 cycles; req_ready is 0 in RESP.
